// File: rtl/xbar_dispatcher.sv
// Crossbar burst dispatcher: grants the scheduler's winning port a capped burst and drains it through a registered output slice.
// Optional watchdog abort is enabled by defining XBAR_DISPATCH_TIMEOUT_EN.
module xbar_dispatcher #(
    parameter int LEN_WIDTH  = 10,
    parameter int ID_WIDTH   = 5,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 16,
    parameter int TIMEOUT    = 255
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [LEN_WIDTH-1:0]               sched_len,
    input  logic [ID_WIDTH-1:0]                sched_id,
    input  logic [(1<<ID_WIDTH)-1:0]           in_valid,
    input  logic [(1<<ID_WIDTH)*DATA_WIDTH-1:0] in_data,
    output logic [(1<<ID_WIDTH)-1:0]           in_ready,
    output logic                               grant_valid,
    output logic [ID_WIDTH-1:0]                grant_id,
    output logic [LEN_WIDTH-1:0]               grant_len,
    output logic                               out_valid,
    output logic [DATA_WIDTH-1:0]              out_data,
    output logic [ID_WIDTH-1:0]                out_id,
    output logic                               out_last,
    input  logic                               out_ready,
    output logic                               busy,
    output logic                               timeout_err
);

    localparam int N = 1 << ID_WIDTH;
    localparam logic [LEN_WIDTH-1:0] MAX_B = LEN_WIDTH'(MAX_BURST);

    typedef enum logic [0:0] {IDLE = 1'b0, BURST = 1'b1} state_t;

    state_t                 state_r;
    logic [ID_WIDTH-1:0]    gid_r;
    logic [LEN_WIDTH-1:0]   remaining_r;
    logic                   load_s;
    logic                   pop_s;
    logic [DATA_WIDTH-1:0]  sel_data_s;
    logic [LEN_WIDTH-1:0]   burst_len_s;

`ifdef XBAR_DISPATCH_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    logic [WD_W-1:0] wd_r;
`else
    assign timeout_err = 1'b0;
`endif

    assign busy = (state_r == BURST);

    // Pop strobe, source word select and capped burst length.
    always_comb begin
        load_s      = !out_valid || out_ready;
        in_ready    = {N{1'b0}};
        sel_data_s  = in_data[int'(gid_r) * DATA_WIDTH +: DATA_WIDTH];
        burst_len_s = (sched_len > MAX_B) ? MAX_B : sched_len;
        if (state_r == BURST && load_s && remaining_r != {LEN_WIDTH{1'b0}}) begin
            in_ready[gid_r] = 1'b1;
        end else begin
            in_ready = {N{1'b0}};
        end
        pop_s = in_valid[gid_r] && in_ready[gid_r];
    end

    // FSM, grant pulse, output slice and optional watchdog.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            gid_r       <= {ID_WIDTH{1'b0}};
            remaining_r <= {LEN_WIDTH{1'b0}};
            grant_valid <= 1'b0;
            grant_id    <= {ID_WIDTH{1'b0}};
            grant_len   <= {LEN_WIDTH{1'b0}};
            out_valid   <= 1'b0;
            out_data    <= {DATA_WIDTH{1'b0}};
            out_id      <= {ID_WIDTH{1'b0}};
            out_last    <= 1'b0;
`ifdef XBAR_DISPATCH_TIMEOUT_EN
            wd_r        <= {WD_W{1'b0}};
            timeout_err <= 1'b0;
`endif
        end else begin
            grant_valid <= 1'b0;
            grant_id    <= {ID_WIDTH{1'b0}};
            grant_len   <= {LEN_WIDTH{1'b0}};
`ifdef XBAR_DISPATCH_TIMEOUT_EN
            timeout_err <= 1'b0;
`endif
            if (pop_s) begin
                out_valid <= 1'b1;
                out_data  <= sel_data_s;
                out_id    <= gid_r;
                out_last  <= (remaining_r == {{(LEN_WIDTH-1){1'b0}}, 1'b1});
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            case (state_r)
                IDLE: begin
                    if (sched_len != {LEN_WIDTH{1'b0}}) begin
                        gid_r       <= sched_id;
                        remaining_r <= burst_len_s;
                        grant_valid <= 1'b1;
                        grant_id    <= sched_id;
                        grant_len   <= burst_len_s;
                        state_r     <= BURST;
`ifdef XBAR_DISPATCH_TIMEOUT_EN
                        wd_r        <= {WD_W{1'b0}};
`endif
                    end
                end
                BURST: begin
                    if (pop_s) begin
                        remaining_r <= remaining_r - {{(LEN_WIDTH-1){1'b0}}, 1'b1};
                        if (remaining_r == {{(LEN_WIDTH-1){1'b0}}, 1'b1}) begin
                            state_r <= IDLE;
                        end
`ifdef XBAR_DISPATCH_TIMEOUT_EN
                        wd_r <= {WD_W{1'b0}};
                    end else if (wd_r == WD_W'(TIMEOUT - 1)) begin
                        // Abort drops the remainder without ever flagging out_last.
                        state_r     <= IDLE;
                        remaining_r <= {LEN_WIDTH{1'b0}};
                        timeout_err <= 1'b1;
                        wd_r        <= {WD_W{1'b0}};
                    end else begin
                        wd_r <= wd_r + {{(WD_W-1){1'b0}}, 1'b1};
`endif
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/xbar_dispatcher.md
# xbar_dispatcher

Crossbar burst dispatcher that sits directly downstream of the tournament-tree scheduler. Each time it is idle it samples the scheduler's winning `(len, id)` pair and grants that input port a burst of `min(len, MAX_BURST)` words. It drains that many words from the granted input queue through a registered output slice, then returns to idle to take the next decision. A one-cycle grant pulse tells the upstream per-port length counters how much was committed, so the scheduler's next decision reflects the words already claimed.

## Interface
- `LEN_WIDTH`, 10, width of pending-length values; matches the scheduler.
- `ID_WIDTH`, 5, port-index width; port count N = 2^ID_WIDTH.
- `DATA_WIDTH`, 32, payload word width.
- `MAX_BURST`, 16, largest burst granted per decision (1 ≤ MAX_BURST < 2^LEN_WIDTH).
- `TIMEOUT`, 255, watchdog limit in cycles; used only with the configuration macro.

Ports:
- `clk` in 1 — the single clock; all state changes on its rising edge.
- `rst_n` in 1 — reset; asynchronous, active-low.
- `sched_len` in LEN_WIDTH — winning pending length from the scheduler.
- `sched_id` in ID_WIDTH — winning port index from the scheduler.
- `in_valid` in N — per-port word available.
- `in_data` in N*DATA_WIDTH — per-port word; port k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- `in_ready` out N — per-port pop strobe; at most one bit set in any cycle.
- `grant_valid` out 1 — one-cycle pulse when a burst is granted.
- `grant_id` out ID_WIDTH — granted port.
- `grant_len` out LEN_WIDTH — granted burst length.
- `out_valid` out 1 — output word valid.
- `out_data` out DATA_WIDTH — output word.
- `out_id` out ID_WIDTH — source port of the output word.
- `out_last` out 1 — final word of a burst.
- `out_ready` in 1 — downstream accepts the output word.
- `busy` out 1 — high while in BURST.
- `timeout_err` out 1 — one-cycle pulse when a burst is aborted by the watchdog.

## Operation
- FSM states: IDLE and BURST.
- Reset value of every output is 0: the state, `remaining`, the output register and the grant register are all cleared.
- IDLE, with `sched_len` != 0:
  - Latch `gid = sched_id` and `remaining = min(sched_len, MAX_BURST)`.
  - Drive `grant_valid`=1, `grant_id`=gid and `grant_len`=remaining, all registered, for exactly one cycle.
  - Enter BURST.
- IDLE, with `sched_len` == 0: stay in IDLE, grant nothing.
- Output slice load enable: `load = !out_valid || out_ready`.
- BURST pop rule:
  - `in_ready[gid] = load && remaining != 0`; all other `in_ready` bits are 0.
  - A pop is `in_valid[gid] && in_ready[gid]`.
- On a pop:
  - The output register captures `in_data[gid]`, `out_id = gid` and `out_last = (remaining == 1)`, and sets `out_valid`.
  - `remaining` decrements by 1.
- When a pop takes `remaining` from 1 to 0, the FSM goes to IDLE on that edge.
- `out_valid` clears on `out_ready` unless a new pop loads the register on the same edge.
- Upstream counters must subtract `grant_len` from port `grant_id` on the edge where `grant_valid` is high. The dispatcher never re-reads `sched_len` during BURST.
- Arithmetic: `min` is an unsigned compare, and the result fits in LEN_WIDTH bits. `remaining` never underflows, because no pop is possible at 0.
- Changes on `sched_id` or `sched_len` during BURST are ignored.
- `busy` = (state == BURST).

## Timing
- Decision to grant: `sched_len` != 0 sampled in IDLE at edge E makes `grant_valid` and `busy` high in the cycle after E.
- Input to output: a pop at edge E makes the word visible on `out_*` in the cycle after E.
- First pop: the earliest pop occurs in the first BURST cycle, so the scheduler's input to the first output word takes 2 cycles.
- Throughput: 1 word/cycle while `out_ready` is held high and `in_valid[gid]` is high.
- Back-to-back bursts: after the final pop the FSM is in IDLE for 1 cycle, then the next grant follows. The gap is one cycle per burst.
- Backpressure: with `out_ready` low and `out_valid` high, `in_ready` is 0 and `out_*` hold stable.
- An asynchronous `rst_n` assertion mid-burst:
  - immediately clears every output, including `out_valid`;
  - discards the undelivered remainder of the burst;
  - emits no partial `out_last`.

## Configuration
- `XBAR_DISPATCH_TIMEOUT_EN` defined:
  - A watchdog counter runs in BURST; it resets to 0 on every pop and increments otherwise.
  - When it reaches `TIMEOUT`, the FSM goes to IDLE, `timeout_err` pulses for one cycle, and the remaining count is dropped.
  - No `out_last` is generated for the aborted burst.
- `XBAR_DISPATCH_TIMEOUT_EN` undefined: no counter exists, `timeout_err` is tied to 0, and a burst waits indefinitely on `in_valid`.

## Test plan
- **Basic burst:** `sched_id`=3, `sched_len`=5, port 3 always valid, `out_ready`=1 → one `grant_valid` pulse with id 3 and len 5, then 5 consecutive words with `out_id`=3 and `out_last` only on the 5th, then `busy` low.
- **Burst cap:** `sched_len`=40, MAX_BURST=16 → `grant_len`=16, exactly 16 pops, the 16th word carries `out_last`, and a new grant follows 1 idle cycle later.
- **Backpressure:** `out_ready` toggles 1,0,0,1 during a 4-word burst → `out_data` holds while `out_ready` is 0, no word is lost or duplicated, and `in_ready[gid]` is 0 in the stalled cycles.
- **Single grant target:** `sched_id` changes mid-burst and every `in_valid` bit is high → only `in_ready[gid]` is ever asserted, and `$onehot0(in_ready)` holds every cycle.
- **Reset mid-burst:** `rst_n` pulses low after 2 of 8 words → all outputs go to 0 immediately, and after release the dispatcher is in IDLE.
- **Timeout (macro defined, TIMEOUT=10):** `in_valid` drops after 1 of 4 words → `timeout_err` pulses 10 cycles after the last pop, and `busy` falls with no `out_last`.
